// File: rtl/freqdetect.sv
// Dominant-frequency detector: scans FFT RAM 1 over [LOBIN, HIBIN] for the bin of
// largest re^2+im^2 and parks the RAM read address on that bin for the weighting stage.
module freqdetect #(
    parameter int unsigned LOBIN  = 1,
    parameter int unsigned HIBIN  = 511,
    parameter int unsigned THRESH = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fftdone,
    input  logic [27:0] ramq1,
    output logic [9:0]  rdaddr1,
    output logic [9:0]  maxbin,
    output logic [27:0] maxpwr,
    output logic        detectdone,
    output logic        nodetect,
    output logic        busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SCAN     = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;
    localparam logic [1:0] COMPLETE = 2'd3;

    localparam logic [9:0]  LO = 10'(LOBIN);
    localparam logic [9:0]  HI = 10'(HIBIN);
    localparam logic [27:0] TH = 28'(THRESH);

    logic [1:0]  state;
    logic        draincnt;
    logic [1:0]  vld;
    logic [9:0]  bin_d1;
    logic [9:0]  bin_d2;

    logic signed [13:0] re;
    logic signed [13:0] im;
    logic signed [27:0] re_sq;
    logic signed [27:0] im_sq;
    logic [27:0]        pwr;

    logic        upd;
    logic [27:0] nxt_pwr;
    logic [9:0]  nxt_bin;

    assign re = ramq1[27:14];
    assign im = ramq1[13:0];

    // Each square is non-negative and at most 2^26, so the 28-bit sum never overflows.
    assign re_sq = re * re;
    assign im_sq = im * im;
    assign pwr   = re_sq + im_sq;

    assign busy = (state == SCAN) || (state == DRAIN);

    always_comb begin
        upd     = vld[1] && (pwr > maxpwr);
        nxt_pwr = upd ? pwr : maxpwr;
        nxt_bin = upd ? bin_d2 : maxbin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            draincnt   <= 1'b0;
            vld        <= '0;
            bin_d1     <= '0;
            bin_d2     <= '0;
            rdaddr1    <= '0;
            maxbin     <= '0;
            maxpwr     <= '0;
            detectdone <= 1'b0;
            nodetect   <= 1'b0;
        end else begin
            detectdone <= 1'b0;
            nodetect   <= 1'b0;
            vld        <= {vld[0], state == SCAN};
            bin_d1     <= rdaddr1;
            bin_d2     <= bin_d1;
            maxpwr     <= nxt_pwr;
            maxbin     <= nxt_bin;
            case (state)
                IDLE, COMPLETE: begin
                    if (fftdone && !detectdone && !nodetect) begin
                        state   <= SCAN;
                        rdaddr1 <= LO;
                        maxpwr  <= '0;
                        maxbin  <= LO;
                    end
                end
                SCAN: begin
                    if (rdaddr1 == HI) begin
                        state    <= DRAIN;
                        draincnt <= 1'b0;
                    end else begin
                        rdaddr1 <= rdaddr1 + 10'd1;
                    end
                end
                DRAIN: begin
                    // The last word is compared in this same cycle, so decide on the next-value max.
                    if (draincnt) begin
                        if (nxt_pwr > TH) begin
                            state      <= COMPLETE;
                            detectdone <= 1'b1;
                            rdaddr1    <= nxt_bin;
                        end else begin
                            state    <= IDLE;
                            nodetect <= 1'b1;
                        end
                    end else begin
                        draincnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freqdetect.sv
// Bench for freqdetect: RAM model with 2-cycle latency, timeline model of the scan
// checked every cycle, and directed tone/tie/silence/edge/retrigger/reset scenarios.
module tb_freqdetect;

    localparam int L1 = 1;
    localparam int H1 = 511;
    localparam int T1 = 0;
    localparam int N1 = H1 - L1 + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        fftdone;
    logic        fftdone2;
    logic [27:0] ramq1, ramq2, q1a, q2a;
    logic [9:0]  rdaddr1, maxbin, rdaddr2, maxbin2;
    logic [27:0] maxpwr, maxpwr2;
    logic        detectdone, nodetect, busy;
    logic        detectdone2, nodetect2, busy2;

    logic [27:0] mem [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freqdetect #(.LOBIN(L1), .HIBIN(H1), .THRESH(T1)) u1 (
        .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(ramq1),
        .rdaddr1(rdaddr1), .maxbin(maxbin), .maxpwr(maxpwr),
        .detectdone(detectdone), .nodetect(nodetect), .busy(busy)
    );

    freqdetect #(.LOBIN(5), .HIBIN(5), .THRESH(10)) u2 (
        .clk(clk), .reset(reset), .fftdone(fftdone2), .ramq1(ramq2),
        .rdaddr1(rdaddr2), .maxbin(maxbin2), .maxpwr(maxpwr2),
        .detectdone(detectdone2), .nodetect(nodetect2), .busy(busy2)
    );

    always @(posedge clk) begin
        q1a   <= mem[rdaddr1];
        ramq1 <= q1a;
        q2a   <= mem[rdaddr2];
        ramq2 <= q2a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] mk(input int r, input int i);
        logic [13:0] a;
        logic [13:0] b;
        a = r[13:0];
        b = i[13:0];
        return {a, b};
    endfunction

    task automatic model_scan(input int lo, input int hi, input int th,
                              output bit det, output logic [9:0] b, output logic [27:0] pw);
        longint best;
        longint r;
        longint im;
        best = 0;
        b = 10'(lo);
        for (int i = lo; i <= hi; i++) begin
            r  = $signed(mem[i][27:14]);
            im = $signed(mem[i][13:0]);
            if (r * r + im * im > best) begin
                best = r * r + im * im;
                b = 10'(i);
            end
        end
        pw  = best[27:0];
        det = best > th;
    endtask

    // Timeline model for u1: p is the cycle index since the accepted fftdone, -1 when quiet.
    int          p = -1;
    logic [9:0]  hold_addr = '0;
    logic [9:0]  hold_bin = '0;
    logic [27:0] hold_pwr = '0;
    bit          e_det;
    logic [9:0]  e_bin;
    logic [27:0] e_pwr;

    always @(negedge clk) begin
        if (!reset) begin
            p = -1;
            hold_addr = '0;
            hold_bin = '0;
            hold_pwr = '0;
        end
        if (p == -1) begin
            chk("quiet_busy", 32'(busy), 0);
            chk("quiet_pulses", 32'({detectdone, nodetect}), 0);
            chk("quiet_addr", 32'(rdaddr1), 32'(hold_addr));
            chk("quiet_bin", 32'(maxbin), 32'(hold_bin));
            chk("quiet_pwr", 32'(maxpwr), 32'(hold_pwr));
        end else if (p <= N1) begin
            chk("scan_busy", 32'(busy), 1);
            chk("scan_pulses", 32'({detectdone, nodetect}), 0);
            chk("scan_addr", 32'(rdaddr1), 32'(L1 + p - 1));
        end else if (p <= N1 + 2) begin
            chk("drain_busy", 32'(busy), 1);
            chk("drain_pulses", 32'({detectdone, nodetect}), 0);
            chk("drain_addr", 32'(rdaddr1), 32'(H1));
        end else begin
            hold_addr = e_det ? e_bin : 10'(H1);
            hold_bin  = e_bin;
            hold_pwr  = e_pwr;
            chk("res_busy", 32'(busy), 0);
            chk("res_detect", 32'(detectdone), 32'(e_det));
            chk("res_nodetect", 32'(nodetect), 32'(!e_det));
            chk("res_addr", 32'(rdaddr1), 32'(hold_addr));
            chk("res_bin", 32'(maxbin), 32'(e_bin));
            chk("res_pwr", 32'(maxpwr), 32'(e_pwr));
        end
        if (p >= 1) begin
            if (p == N1 + 3) p = -1;
            else p++;
        end else if (reset && fftdone) begin
            model_scan(L1, H1, T1, e_det, e_bin, e_pwr);
            p = 1;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic start_scan();
        fftdone = 1'b1;
        @(posedge clk); #1;
        fftdone = 1'b0;
    endtask

    task automatic wait_result(input int start, output int cyc);
        cyc = start;
        while (!(detectdone || nodetect) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int cyc;

    initial begin
        reset = 1'b0;
        fftdone = 1'b0;
        fftdone2 = 1'b0;
        clear_mem();
        idle(2);
        chk("rst_addr", 32'(rdaddr1), 0);
        chk("rst_bin", 32'(maxbin), 0);
        chk("rst_pwr", 32'(maxpwr), 0);
        chk("rst_flags", 32'({detectdone, nodetect, busy}), 0);
        reset = 1'b1;
        idle(2);

        // Single tone
        for (int i = 0; i < 1024; i++) mem[i] = mk(3, 4);
        mem[37] = mk(1000, -500);
        start_scan();
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_addr_c1", 32'(rdaddr1), 1);
        wait_result(1, cyc);
        chk("t1_cycle", 32'(cyc), 514);
        chk("t1_detect", 32'(detectdone), 1);
        chk("t1_bin", 32'(maxbin), 37);
        chk("t1_pwr", 32'(maxpwr), 1250000);
        chk("t1_addr", 32'(rdaddr1), 37);
        fftdone = 1'b1;
        @(posedge clk); #1;
        fftdone = 1'b0;
        chk("t1_pulse_fft_ignored", 32'(busy), 0);
        idle(3);
        chk("t1_hold", 32'(rdaddr1), 37);

        // Retrigger: mid-scan fftdone ignored, then new peak from complete
        start_scan();
        repeat (49) @(posedge clk);
        #1;
        fftdone = 1'b1;
        @(posedge clk); #1;
        fftdone = 1'b0;
        wait_result(51, cyc);
        chk("t5a_cycle", 32'(cyc), 514);
        chk("t5a_bin", 32'(maxbin), 37);
        idle(2);
        mem[12] = mk(2000, 0);
        start_scan();
        wait_result(1, cyc);
        chk("t5b_cycle", 32'(cyc), 514);
        chk("t5b_bin", 32'(maxbin), 12);
        chk("t5b_pwr", 32'(maxpwr), 4000000);
        idle(2);

        // Tie at full scale
        clear_mem();
        mem[100] = mk(-8192, -8192);
        mem[200] = mk(-8192, -8192);
        start_scan();
        wait_result(1, cyc);
        chk("t2_detect", 32'(detectdone), 1);
        chk("t2_bin", 32'(maxbin), 100);
        chk("t2_pwr", 32'(maxpwr), 134217728);
        idle(2);

        // No signal
        clear_mem();
        start_scan();
        wait_result(1, cyc);
        chk("t3_cycle", 32'(cyc), 514);
        chk("t3_nodetect", 32'(nodetect), 1);
        chk("t3_detect", 32'(detectdone), 0);
        chk("t3_bin", 32'(maxbin), 1);
        chk("t3_pwr", 32'(maxpwr), 0);
        chk("t3_addr", 32'(rdaddr1), 511);
        idle(2);

        // Edge bins: DC excluded, last bin counted
        mem[0] = mk(5000, 0);
        mem[511] = mk(100, 0);
        start_scan();
        wait_result(1, cyc);
        chk("t4_bin", 32'(maxbin), 511);
        chk("t4_pwr", 32'(maxpwr), 10000);
        chk("t4_addr", 32'(rdaddr1), 511);
        idle(2);

        // Reset mid-scan
        clear_mem();
        mem[12] = mk(2000, 0);
        start_scan();
        repeat (199) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_addr", 32'(rdaddr1), 0);
        chk("t6_bin", 32'(maxbin), 0);
        chk("t6_pwr", 32'(maxpwr), 0);
        chk("t6_flags", 32'({detectdone, nodetect, busy}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        start_scan();
        wait_result(1, cyc);
        chk("t6_cycle", 32'(cyc), 514);
        chk("t6_bin_after", 32'(maxbin), 12);
        idle(2);

        // Single-bin range on u2 (bin 5, threshold 10)
        mem[4] = mk(4000, 0);
        mem[6] = mk(4000, 0);
        mem[5] = mk(3, 1);
        for (int run = 0; run < 2; run++) begin
            fftdone2 = 1'b1;
            @(posedge clk); #1;
            fftdone2 = 1'b0;
            chk("u2_busy_c1", 32'(busy2), 1);
            cyc = 1;
            while (!(detectdone2 || nodetect2) && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("u2_cycle", 32'(cyc), 4);
            chk("u2_detect", 32'(detectdone2), (run == 0) ? 0 : 1);
            chk("u2_nodetect", 32'(nodetect2), (run == 0) ? 1 : 0);
            chk("u2_bin", 32'(maxbin2), 5);
            chk("u2_pwr", 32'(maxpwr2), (run == 0) ? 10 : 13);
            chk("u2_addr", 32'(rdaddr2), 5);
            idle(2);
            mem[5] = mk(3, -2);
        end

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
